// File: rtl/qos_traffic_gen_if.sv
// rtl/qos_traffic_gen_if.sv - ingress push/data and per-class drain pop bus of the QoS traffic generator
interface qos_traffic_gen_if #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 12
);
    logic                push;
    logic [DATA_W-1:0]   data_out;
    logic                pause;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] fifo_empty;

    modport master (output push, output data_out, output pop, input pause, input fifo_empty);
    modport slave  (input push, input data_out, input pop, output pause, output fifo_empty);
endinterface

// File: rtl/qos_traffic_gen.sv
// rtl/qos_traffic_gen.sv - QoS path sequencer: config, class-tagged fill, gap, round-robin drain
// Optional QOS_TG_LFSR_EN: payload from a 16-bit LFSR instead of the running push count.
module qos_traffic_gen #(
    parameter int CHANNELS     = 4,
    parameter int DATA_W       = 12,
    parameter int WORDS_PER_CH = 4,
    parameter int CFG_CYCLES   = 3,
    parameter int GAP_CYCLES   = 10,
    parameter int UMB_W        = 4,
    parameter int CNT_W        = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [UMB_W-1:0]    cfg_umbral_hi_i,
    input  logic [UMB_W-1:0]    cfg_umbral_lo_i,
    qos_traffic_gen_if.master   bus,
    output logic                init_o,
    output logic [UMB_W-1:0]    umbral_high_o,
    output logic [UMB_W-1:0]    umbral_low_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    sent_cnt_o,
    output logic [CNT_W-1:0]    popped_cnt_o
);
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int PW    = DATA_W - CH_W;
    localparam int CFG_W = $clog2(CFG_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [7:0]       WORD_LAST = 8'(WORDS_PER_CH - 1);
    localparam logic [CFG_W-1:0] CFG_LAST  = CFG_W'(CFG_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_FILL, S_GAP, S_DRAIN, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CH_W-1:0]    class_q, class_d;
    logic [7:0]         word_q, word_d;
    logic [CFG_W-1:0]   cfg_cnt_q, cfg_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic               all_empty_q, all_empty_d;
    logic [UMB_W-1:0]   umb_hi_q, umb_hi_d;
    logic [UMB_W-1:0]   umb_lo_q, umb_lo_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [CNT_W-1:0]   popped_q, popped_d;
    logic [PW-1:0]      payload;
    logic               found;
    logic [CH_W-1:0]    sel;
    logic [CH_W-1:0]    idx;

`ifdef QOS_TG_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;
    assign payload = lfsr_q[PW-1:0];
`else
    assign payload = PW'(sent_q);
`endif

    // Cyclic search for the first non-empty FIFO at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = rr_q + CH_W'(i);
            if (!found && !bus.fifo_empty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        word_d      = word_q;
        cfg_cnt_d   = cfg_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rr_d        = rr_q;
        all_empty_d = all_empty_q;
        umb_hi_d    = umb_hi_q;
        umb_lo_d    = umb_lo_q;
        sent_d      = sent_q;
        popped_d    = popped_q;
`ifdef QOS_TG_LFSR_EN
        lfsr_d      = lfsr_q;
`endif
        init_o      = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_CONFIG;
                    umb_hi_d    = cfg_umbral_hi_i;
                    umb_lo_d    = cfg_umbral_lo_i;
                    class_d     = '0;
                    word_d      = '0;
                    cfg_cnt_d   = '0;
                    gap_cnt_d   = '0;
                    rr_d        = '0;
                    all_empty_d = 1'b0;
                    sent_d      = '0;
                    popped_d    = '0;
`ifdef QOS_TG_LFSR_EN
                    lfsr_d      = LFSR_SEED;
`endif
                end
            end
            S_CONFIG: begin
                init_o = 1'b1;
                if (cfg_cnt_q == CFG_LAST) state_d = S_FILL;
                else                       cfg_cnt_d = cfg_cnt_q + CFG_W'(1);
            end
            S_FILL: begin
                if (!bus.pause) begin
                    bus.push = 1'b1;
                    sent_d   = (&sent_q) ? sent_q : sent_q + CNT_W'(1);
`ifdef QOS_TG_LFSR_EN
                    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
                    if (word_q == WORD_LAST) begin
                        word_d = '0;
                        if (class_q == CH_LAST) state_d = S_GAP;
                        else                    class_d = class_q + CH_W'(1);
                    end else begin
                        word_d = word_q + 8'd1;
                    end
                end
            end
            S_GAP: begin
                all_empty_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) state_d = S_DRAIN;
                else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            S_DRAIN: begin
                all_empty_d = &bus.fifo_empty;
                if (found) begin
                    bus.pop[sel] = 1'b1;
                    rr_d         = sel + CH_W'(1);
                    popped_d     = (&popped_q) ? popped_q : popped_q + CNT_W'(1);
                end
                if ((&bus.fifo_empty) && all_empty_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            class_q     <= '0;
            word_q      <= '0;
            cfg_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rr_q        <= '0;
            all_empty_q <= 1'b0;
            umb_hi_q    <= '0;
            umb_lo_q    <= '0;
            sent_q      <= '0;
            popped_q    <= '0;
`ifdef QOS_TG_LFSR_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            state_q     <= state_d;
            class_q     <= class_d;
            word_q      <= word_d;
            cfg_cnt_q   <= cfg_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rr_q        <= rr_d;
            all_empty_q <= all_empty_d;
            umb_hi_q    <= umb_hi_d;
            umb_lo_q    <= umb_lo_d;
            sent_q      <= sent_d;
            popped_q    <= popped_d;
`ifdef QOS_TG_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    // Data is forced to zero outside FILL so idle/reset states present a clean bus.
    assign bus.data_out  = (state_q == S_FILL) ? {class_q, payload} : '0;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = (state_q == S_DONE);
    assign umbral_high_o = umb_hi_q;
    assign umbral_low_o  = umb_lo_q;
    assign sent_cnt_o    = sent_q;
    assign popped_cnt_o  = popped_q;
endmodule

// File: tb/tb_qos_traffic_gen.sv
// tb/tb_qos_traffic_gen.sv - directed self-checking bench for qos_traffic_gen
module tb_qos_traffic_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cfg_hi, cfg_lo;
    logic        init, busy, done;
    logic [3:0]  umb_hi, umb_lo;
    logic [15:0] sent_cnt, popped_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    logic [9:0]  m_cnt;

    always #5 clk = ~clk;

    qos_traffic_gen_if #(.CHANNELS(4), .DATA_W(12)) bus ();

    qos_traffic_gen dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .start_i         (start),
        .cfg_umbral_hi_i (cfg_hi),
        .cfg_umbral_lo_i (cfg_lo),
        .bus             (bus),
        .init_o          (init),
        .umbral_high_o   (umb_hi),
        .umbral_low_o    (umb_lo),
        .busy_o          (busy),
        .done_o          (done),
        .sent_cnt_o      (sent_cnt),
        .popped_cnt_o    (popped_cnt)
    );

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_lfsr = 16'hACE1;
        m_cnt  = '0;
    endtask

    task automatic model_adv;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_cnt  = m_cnt + 10'd1;
    endtask

    function automatic logic [11:0] exp_word(int idx);
        logic [1:0] cls;
        cls = 2'(idx / 4);
`ifdef QOS_TG_LFSR_EN
        return {cls, m_lfsr[9:0]};
`else
        return {cls, m_cnt};
`endif
    endfunction

    task automatic kick(input logic [3:0] hi, input logic [3:0] lo);
        cfg_hi = hi;
        cfg_lo = lo;
        start  = 1'b1;
        step();
        start  = 1'b0;
        #1;
    endtask

    task automatic wait_config(output int n);
        n = 0;
        while (init && n < 20) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; cfg_hi = 4'd7; cfg_lo = 4'd3;
        bus.pause = 1'b0; bus.fifo_empty = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({bus.push, bus.pop, init, done, busy} !== 8'd0) begin
                bad++; $display("FAIL reset_ctrl cyc=%0d got=%b exp=0", c, {bus.push, bus.pop, init, done, busy});
            end
            total++;
            if ({umb_hi, umb_lo, sent_cnt, popped_cnt, bus.data_out} !== 52'd0) begin
                bad++; $display("FAIL reset_regs cyc=%0d got=%h exp=0", c, {umb_hi, umb_lo, sent_cnt, popped_cnt, bus.data_out});
            end
        end
        reset = 1'b0; start = 1'b0;
        step();
        total++;
        if ({busy, init, done} !== 3'b000) begin
            bad++; $display("FAIL reset_start_ignored got=%b exp=000", {busy, init, done});
        end
    endtask

    task automatic test_config;
        int n;
        kick(4'd5, 4'd1);
        model_reset();
        total++;
        if ({umb_hi, umb_lo} !== {4'd5, 4'd1}) begin
            bad++; $display("FAIL cfg_umbral got=%h/%h exp=5/1", umb_hi, umb_lo);
        end
        total++;
        if ({init, busy} !== 2'b11) begin
            bad++; $display("FAIL cfg_init_busy got=%b exp=11", {init, busy});
        end
        wait_config(n);
        total++;
        if (n != 3) begin
            bad++; $display("FAIL cfg_init_cycles got=%0d exp=3", n);
        end
        total++;
        if ({bus.push, bus.data_out} !== {1'b1, exp_word(0)}) begin
            bad++; $display("FAIL cfg_first_push got=%b/%h exp=1/%h", bus.push, bus.data_out, exp_word(0));
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            total++;
            if ({bus.push, bus.data_out} !== {1'b1, exp_word(i)}) begin
                bad++; $display("FAIL fill_word i=%0d got=%b/%h exp=1/%h", i, bus.push, bus.data_out, exp_word(i));
            end
            model_adv();
        end
        step();
        total++;
        if ({bus.push, busy, sent_cnt} !== {1'b0, 1'b1, 16'd16}) begin
            bad++; $display("FAIL fill_end got push=%b busy=%b sent=%0d exp 0/1/16", bus.push, busy, sent_cnt);
        end
    endtask

    task automatic test_drain;
        int n;
        logic [3:0] exp_pop;
        bus.fifo_empty = 4'b1010;
        #1;
        n = 0;
        while (bus.pop == 4'd0 && n < 40) begin
            n++;
            step();
        end
        total++;
        if (n != 10) begin
            bad++; $display("FAIL gap_cycles got=%0d exp=10", n);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            exp_pop = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            total++;
            if (bus.pop !== exp_pop) begin
                bad++; $display("FAIL drain_rr k=%0d got=%b exp=%b", k, bus.pop, exp_pop);
            end
        end
        step();
        bus.fifo_empty = 4'b1111;
        #1;
        total++;
        if ({bus.pop, done} !== 5'd0) begin
            bad++; $display("FAIL drain_empty1 got pop=%b done=%b exp 0000/0", bus.pop, done);
        end
        step();
        total++;
        if ({bus.pop, done, busy} !== 6'b000001) begin
            bad++; $display("FAIL drain_empty2 got pop=%b done=%b busy=%b exp 0000/0/1", bus.pop, done, busy);
        end
        step();
        total++;
        if ({done, busy, bus.pop} !== 6'b100000) begin
            bad++; $display("FAIL drain_done got done=%b busy=%b pop=%b exp 1/0/0000", done, busy, bus.pop);
        end
        total++;
        if ({popped_cnt, sent_cnt} !== {16'd4, 16'd16}) begin
            bad++; $display("FAIL drain_counts got popped=%0d sent=%0d exp 4/16", popped_cnt, sent_cnt);
        end
    endtask

    task automatic test_pause;
        int n;
        kick(4'd9, 4'd2);
        total++;
        if ({umb_hi, umb_lo, popped_cnt, sent_cnt} !== {4'd9, 4'd2, 16'd0, 16'd0}) begin
            bad++; $display("FAIL pause_restart got umb=%h/%h popped=%0d sent=%0d exp 9/2/0/0", umb_hi, umb_lo, popped_cnt, sent_cnt);
        end
        wait_config(n);
        model_reset();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            if (i == 6) begin
                for (int p = 0; p < 5; p++) begin
                    if (p > 0) step();
                    bus.pause = 1'b1;
                    start = (p == 2);
                    #1;
                    total++;
                    if ({bus.push, bus.data_out} !== {1'b0, exp_word(i)}) begin
                        bad++; $display("FAIL pause_hold p=%0d got=%b/%h exp=0/%h", p, bus.push, bus.data_out, exp_word(i));
                    end
                end
                step();
                bus.pause = 1'b0;
                start = 1'b0;
                #1;
            end
            total++;
            if ({bus.push, bus.data_out} !== {1'b1, exp_word(i)}) begin
                bad++; $display("FAIL pause_word i=%0d got=%b/%h exp=1/%h", i, bus.push, bus.data_out, exp_word(i));
            end
            model_adv();
        end
        step();
        total++;
        if ({bus.push, sent_cnt} !== {1'b0, 16'd16}) begin
            bad++; $display("FAIL pause_total got push=%b sent=%0d exp 0/16", bus.push, sent_cnt);
        end
        bus.fifo_empty = 4'b1111;
        n = 0;
        while (!done && n < 40) begin
            n++;
            step();
        end
        total++;
        if (done !== 1'b1 || popped_cnt !== 16'd0) begin
            bad++; $display("FAIL pause_done got done=%b popped=%0d exp 1/0", done, popped_cnt);
        end
    endtask

    task automatic test_reset_midfill;
        int n;
        kick(4'd5, 4'd1);
        wait_config(n);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            model_adv();
            step();
        end
        total++;
        if ({bus.push, bus.data_out} !== {1'b1, exp_word(4)}) begin
            bad++; $display("FAIL midfill_word4 got=%b/%h exp=1/%h", bus.push, bus.data_out, exp_word(4));
        end
        reset = 1'b1;
        step();
        total++;
        if ({bus.push, bus.pop, init, done, busy} !== 8'd0 || {sent_cnt, bus.data_out} !== 28'd0) begin
            bad++; $display("FAIL midfill_reset got ctrl=%b sent=%0d data=%h exp 0", {bus.push, bus.pop, init, done, busy}, sent_cnt, bus.data_out);
        end
        reset = 1'b0;
        step();
        kick(4'd5, 4'd1);
        wait_config(n);
        model_reset();
        total++;
        if ({bus.push, bus.data_out, sent_cnt} !== {1'b1, exp_word(0), 16'd0}) begin
            bad++; $display("FAIL restart_first got=%b/%h sent=%0d exp=1/%h/0", bus.push, bus.data_out, sent_cnt, exp_word(0));
        end
        model_adv();
        step();
        total++;
        if ({bus.push, bus.data_out, sent_cnt} !== {1'b1, exp_word(1), 16'd1}) begin
            bad++; $display("FAIL restart_second got=%b/%h sent=%0d exp=1/%h/1", bus.push, bus.data_out, sent_cnt, exp_word(1));
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_fill();
        test_drain();
        test_pause();
        test_reset_midfill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
